// File: rtl/ldl_reg_pkg.sv
// Shared helpers for the ldl_reg statistics blocks: counter and tag widths,
// and modular distance between sample tags.
package ldl_reg_pkg;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a sample tag that counts modulo 2*depth.
    function automatic int unsigned tag_w(input int unsigned depth);
        return $clog2(2 * depth);
    endfunction

    // Age of tag 'old' relative to tag 'cur', with both taken modulo 2*depth.
    function automatic int unsigned tag_dist(input int unsigned cur,
                                             input int unsigned old,
                                             input int unsigned depth);
        if (cur >= old) begin
            return cur - old;
        end
        return cur + 2 * depth - old;
    endfunction

endpackage

// File: rtl/ldl_min_deque.sv
// Monotonic (strictly ascending front to back) deque of {value, tag} entries.
// Front always holds the minimum of the live window. 'front' is the front
// value after this edge's update, so the parent can register it directly.
module ldl_min_deque
    import ldl_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned TAG_W = tag_w(DEPTH),
    localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] x,
    input  logic [TAG_W-1:0] tag,
    output logic [WIDTH-1:0] front,
    output logic [CNT_W-1:0] occ
);

    typedef struct packed {
        logic [WIDTH-1:0] value;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;

    int unsigned occ_n;
    int unsigned keep;
    int unsigned shift;
    int unsigned src;

    // Back-pop suffix, front expiry and push, all resolved in one pass.
    always_comb begin
        occ_n = 32'(occ_q);
        keep  = 0;
        shift = 0;
        src   = 0;
        ent_d = ent_q;
        occ_d = occ_q;

        // Entries are strictly ascending, so those below x form a prefix;
        // counting them gives the survivor count without a priority search.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i < occ_n && ent_q[i].value < x) begin
                keep = keep + 1;
            end
        end

        // Only the surviving front can be exactly DEPTH samples old.
        if (keep != 0 && tag_dist(32'(tag), 32'(ent_q[0].tag), DEPTH) == DEPTH) begin
            shift = 1;
        end

        if (clr) begin
            occ_d = '0;
            if (push) begin
                ent_d[0] = '{value: x, tag: tag};
                occ_d    = CNT_W'(1);
            end
        end else if (push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                src = (i + shift < DEPTH) ? i + shift : i;
                if (i + shift < keep) begin
                    ent_d[i] = ent_q[src];
                end else if (i + shift == keep) begin
                    ent_d[i] = '{value: x, tag: tag};
                end
            end
            occ_d = CNT_W'(keep - shift + 1);
        end
    end

    // Occupancy register; reset empties the deque.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Entry storage; contents beyond occupancy are don't-care, so no reset.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign front = ent_d[0].value;
    assign occ   = occ_q;

endmodule

// File: rtl/ldl_reg_min_win.sv
// Sliding-window minimum over the last DEPTH accepted samples.
// Holds the tag counter, window count and registered result; the deque
// sub-module holds the candidate minima.
module ldl_reg_min_win
    import ldl_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             vld,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             y_vld,
    output logic             full,
    output logic [CNT_W-1:0] cnt
);

    localparam int unsigned TAG_W = tag_w(DEPTH);
    localparam logic [TAG_W-1:0] TAG_LAST = TAG_W'(2 * DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

    logic [TAG_W-1:0] tag_q, tag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [TAG_W-1:0] push_tag;
    logic [WIDTH-1:0] dq_front;
    logic [CNT_W-1:0] dq_occ;

    // A clear restarts tagging, so a sample accepted with clr gets tag 0.
    assign push_tag = clr ? '0 : tag_q;

    ldl_min_deque #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_deque (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (vld),
        .x     (x),
        .tag   (push_tag),
        .front (dq_front),
        .occ   (dq_occ)
    );

    // Next-state for tag counter, window count and result (clr over vld).
    always_comb begin
        tag_d = tag_q;
        cnt_d = cnt_q;
        y_d   = y_q;
        if (vld) begin
            tag_d = (push_tag == TAG_LAST) ? '0 : push_tag + TAG_W'(1);
            if (clr) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            y_d = dq_front;
        end else if (clr) begin
            tag_d = '0;
            cnt_d = '0;
            y_d   = '1;
        end
    end

    // State registers; reset dominates clr and vld.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= '0;
            cnt_q <= '0;
            y_q   <= '1;
        end else begin
            tag_q <= tag_d;
            cnt_q <= cnt_d;
            y_q   <= y_d;
        end
    end

    // The deque only ever holds distinct samples from the live window.
    occ_bound_a: assert property (@(posedge clk) disable iff (rst)
        (dq_occ <= cnt_q) && (cnt_q <= CNT_MAX));

    assign y     = y_q;
    assign cnt   = cnt_q;
    assign y_vld = (cnt_q != '0);
    assign full  = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_ldl_reg_min_win.sv
// Bench for ldl_reg_min_win: directed scenarios on DEPTH=4, then a random
// regression on DEPTH=4, 2 and 7 against a brute-force window model.
module tb_ldl_reg_min_win;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       vld = 1'b0;
    logic [7:0] x   = 8'h00;

    logic [7:0] y4, y2, y7;
    logic       yv4, yv2, yv7;
    logic       f4, f2, f7;
    logic [2:0] c4;
    logic [1:0] c2;
    logic [2:0] c7;

    int checks = 0;
    int errors = 0;

    // Accepted samples since last rst/clr, oldest first.
    logic [7:0] hist[$];

    always #5 clk = ~clk;

    ldl_reg_min_win #(.WIDTH(8), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .clr(clr), .vld(vld), .x(x),
        .y(y4), .y_vld(yv4), .full(f4), .cnt(c4)
    );
    ldl_reg_min_win #(.WIDTH(8), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .vld(vld), .x(x),
        .y(y2), .y_vld(yv2), .full(f2), .cnt(c2)
    );
    ldl_reg_min_win #(.WIDTH(8), .DEPTH(7)) dut7 (
        .clk(clk), .rst(rst), .clr(clr), .vld(vld), .x(x),
        .y(y7), .y_vld(yv7), .full(f7), .cnt(c7)
    );

    function automatic logic [7:0] m_min(input int d);
        logic [7:0] m = 8'hFF;
        int n = hist.size();
        int lo = (n > d) ? n - d : 0;
        for (int i = lo; i < n; i++) begin
            if (hist[i] < m) m = hist[i];
        end
        return m;
    endfunction

    function automatic int m_cnt(input int d);
        return (hist.size() < d) ? hist.size() : d;
    endfunction

    // Drive one edge, then update the model and leave time at edge+1.
    task automatic cyc(input logic r, input logic c, input logic v, input logic [7:0] xv);
        rst = r; clr = c; vld = v; x = xv;
        @(posedge clk);
        #1;
        if (r) begin
            hist.delete();
        end else begin
            if (c) hist.delete();
            if (v) begin
                hist.push_back(xv);
                if (hist.size() > 64) void'(hist.pop_front());
            end
        end
        rst = 1'b0; clr = 1'b0; vld = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b0, 1'b1, 8'h05);
            checks++;
            if (y4 !== 8'hFF || yv4 !== 1'b0 || f4 !== 1'b0 || c4 !== 3'd0) begin
                errors++;
                $display("FAIL reset: y=%h y_vld=%b full=%b cnt=%0d, want y=ff y_vld=0 full=0 cnt=0",
                         y4, yv4, f4, c4);
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (c4 !== 3'd0 || yv4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_capture: cnt=%0d y_vld=%b, want 0 0", c4, yv4);
        end
    endtask

    task automatic test_expiry();
        logic [7:0] seq [6] = '{8'd5, 8'd3, 8'd7, 8'd9, 8'd8, 8'd6};
        logic [7:0] exp [6] = '{8'd5, 8'd3, 8'd3, 8'd3, 8'd3, 8'd6};
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 1'b1, seq[i]);
            checks++;
            if (y4 !== exp[i] || f4 !== (i >= 3)) begin
                errors++;
                $display("FAIL expiry[%0d]: y=%0d full=%b, want y=%0d full=%b",
                         i, y4, f4, exp[i], (i >= 3));
            end
        end
    endtask

    task automatic test_monotonic();
        logic [7:0] exp_up [6] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3};
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'(i + 1));
            checks++;
            if (y4 !== exp_up[i]) begin
                errors++;
                $display("FAIL ascending[%0d]: y=%0d, want %0d", i, y4, exp_up[i]);
            end
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'(9 - i));
            checks++;
            if (y4 !== 8'(9 - i)) begin
                errors++;
                $display("FAIL descending[%0d]: y=%0d, want %0d", i, y4, 9 - i);
            end
        end
    endtask

    task automatic test_dup_gaps();
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 8'd4);
        checks++;
        if (y4 !== 8'd4 || c4 !== 3'd4) begin
            errors++;
            $display("FAIL dup4: y=%0d cnt=%0d, want 4 4", y4, c4);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'd9);
            for (int g = 0; g < 3; g++) begin
                cyc(1'b0, 1'b0, 1'b0, 8'($urandom));
                checks++;
                if (y4 !== 8'd4 || c4 !== 3'd4) begin
                    errors++;
                    $display("FAIL gap[%0d.%0d]: y=%0d cnt=%0d, want 4 4", i, g, y4, c4);
                end
            end
        end
        cyc(1'b0, 1'b0, 1'b1, 8'd9);
        checks++;
        if (y4 !== 8'd9) begin
            errors++;
            $display("FAIL fourth9: y=%0d, want 9", y4);
        end
    endtask

    task automatic test_clear();
        cyc(1'b0, 1'b0, 1'b1, 8'd30);
        cyc(1'b0, 1'b0, 1'b1, 8'd10);
        cyc(1'b0, 1'b0, 1'b1, 8'd40);
        cyc(1'b0, 1'b1, 1'b1, 8'd20);
        checks++;
        if (y4 !== 8'd20 || c4 !== 3'd1 || yv4 !== 1'b1) begin
            errors++;
            $display("FAIL clr_vld: y=%0d cnt=%0d y_vld=%b, want 20 1 1", y4, c4, yv4);
        end
        cyc(1'b0, 1'b1, 1'b0, 8'd0);
        checks++;
        if (y4 !== 8'hFF || yv4 !== 1'b0 || c4 !== 3'd0) begin
            errors++;
            $display("FAIL clr_idle: y=%h y_vld=%b cnt=%0d, want ff 0 0", y4, yv4, c4);
        end
        cyc(1'b0, 1'b0, 1'b1, 8'd7);
        cyc(1'b1, 1'b1, 1'b1, 8'd2);
        checks++;
        if (y4 !== 8'hFF || yv4 !== 1'b0 || f4 !== 1'b0 || c4 !== 3'd0) begin
            errors++;
            $display("FAIL clr_rst: y=%h y_vld=%b full=%b cnt=%0d, want ff 0 0 0",
                     y4, yv4, f4, c4);
        end
    endtask

    task automatic test_random();
        int         dep [3] = '{4, 2, 7};
        logic [7:0] ys  [3];
        logic       yvs [3];
        logic       fs  [3];
        int         cs  [3];
        logic       r, c, v;
        logic [7:0] xv;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int n = 0; n < 10000; n++) begin
            r  = ($urandom_range(0, 299) == 0);
            c  = ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 9) < 7);
            xv = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            cyc(r, c, v, xv);
            ys  = '{y4, y2, y7};
            yvs = '{yv4, yv2, yv7};
            fs  = '{f4, f2, f7};
            cs  = '{int'(c4), int'(c2), int'(c7)};
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ys[k] !== m_min(dep[k]) || cs[k] != m_cnt(dep[k])
                    || yvs[k] !== (m_cnt(dep[k]) != 0) || fs[k] !== (m_cnt(dep[k]) == dep[k])) begin
                    errors++;
                    $display("FAIL random D=%0d cyc=%0d: y=%0d cnt=%0d y_vld=%b full=%b, want y=%0d cnt=%0d y_vld=%b full=%b",
                             dep[k], n, ys[k], cs[k], yvs[k], fs[k], m_min(dep[k]),
                             m_cnt(dep[k]), (m_cnt(dep[k]) != 0), (m_cnt(dep[k]) == dep[k]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_expiry();
        test_monotonic();
        test_dup_gaps();
        test_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
